// File: rtl/aurora_rx_32to16_adapter.sv
// ---------------------------------------------------------------------------
// aurora_rx_32to16_adapter
//
// Purpose:
//   Receive-side width downconverter for the Aurora RX user interface. 32-bit
//   beats from the core arrive with no backpressure. They are buffered in a
//   FIFO and replayed downstream as 16-bit half-words with full AXI4S
//   handshaking. Occupancy hysteresis drives NFC XOFF toward the link
//   partner. If the FIFO still overflows, the current frame is truncated
//   and marked bad, so frame boundaries stay intact.
//
// Ports:
//   user_clk           clock (single domain)
//   ur_ch_reset        synchronous active-high reset
//   s_axis_rx_*        32-bit RX stream from the core (tdata byte 0 = [0:7])
//   m_axis_*           16-bit stream to the consumer (registered outputs)
//   nfc_xoff           to the core wrapper's s_axis_tx_nfc_xoff
//   overflow_err       one-cycle pulse per overflow event
//   fill_count         current FIFO occupancy in entries
// ---------------------------------------------------------------------------
module aurora_rx_32to16_adapter #(
   parameter int DEPTH       = 32,   // power of 2, >= 8; last slot kept for truncation
   parameter int XOFF_THRESH = 20,
   parameter int XON_THRESH  = 8     // must be below XOFF_THRESH
) (
   input  logic                   user_clk,
   input  logic                   ur_ch_reset,
   input  logic [0:31]            s_axis_rx_tdata,
   input  logic [0:3]             s_axis_rx_tkeep,
   input  logic                   s_axis_rx_tvalid,
   input  logic                   s_axis_rx_tlast,
   input  logic                   s_axis_rx_tuser,
   output logic [0:15]            m_axis_tdata,
   output logic [0:1]             m_axis_tkeep,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic                   nfc_xoff,
   output logic                   overflow_err,
   output logic [$clog2(DEPTH):0] fill_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_FULL      = CW'(DEPTH);
   localparam logic [CW-1:0] C_LAST_SLOT = CW'(DEPTH - 1);
   localparam logic [CW-1:0] C_XOFF      = CW'(XOFF_THRESH);
   localparam logic [CW-1:0] C_XON       = CW'(XON_THRESH);
   localparam logic [CW-1:0] C_ONE       = CW'(1);
   localparam logic [CW-1:0] C_TWO       = CW'(2);

   typedef enum logic {ST_PASS, ST_DROP} state_t;

   // FIFO storage (no reset: validity is tracked by pointers/count)
   logic [0:31]   r_mem_data [DEPTH];
   logic [0:3]    r_mem_keep [DEPTH];
   logic          r_mem_last [DEPTH];
   logic          r_mem_user [DEPTH];

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_cnt;
   state_t        r_state;
   logic          r_xoff;
   logic          r_ovf;

   // output register stage; r_half=1 means the second half of the head is shown
   logic          r_half;
   logic          r_tvalid;
   logic [0:15]   r_tdata;
   logic [0:1]    r_tkeep;
   logic          r_tlast;
   logic          r_tuser;

   state_t        w_state_nxt;
   logic          w_accept;
   logic          w_wr;
   logic          w_ovf;
   logic          w_trunc;
   logic          w_xfer;
   logic          w_pop;
   logic [AW-1:0] w_rptr_nxt;

   logic [0:31]   w_hd_data;
   logic [0:3]    w_hd_keep;
   logic          w_hd_last;
   logic          w_hd_user;
   logic [0:31]   w_nx_data;
   logic [0:3]    w_nx_keep;
   logic          w_nx_last;
   logic          w_nx_user;

   logic          w_o_valid;
   logic [0:15]   w_o_data;
   logic [0:1]    w_o_keep;
   logic          w_o_last;
   logic          w_o_user;
   logic          w_half_nxt;

   // ---------------- write side ----------------
   // Decisions use the start-of-cycle count only; a same-cycle pop never
   // frees room for the incoming beat.
   assign w_accept = s_axis_rx_tvalid & (r_state == ST_PASS);
   assign w_wr     = w_accept & (r_cnt < C_FULL);
   assign w_ovf    = w_accept & (r_cnt >= C_LAST_SLOT);
   // Writing into the reserved slot closes the frame as a bad one.
   assign w_trunc  = (r_cnt == C_LAST_SLOT);

   always_ff @(posedge user_clk) begin
      if (w_wr) begin
         r_mem_data[r_wptr] <= s_axis_rx_tdata;
         r_mem_keep[r_wptr] <= s_axis_rx_tkeep;
         r_mem_last[r_wptr] <= s_axis_rx_tlast | w_trunc;
         r_mem_user[r_wptr] <= s_axis_rx_tuser | w_trunc;
      end
   end

   // ---------------- frame-drop FSM ----------------
   always_ff @(posedge user_clk) begin
      if (ur_ch_reset) r_state <= ST_PASS;
      else             r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_PASS: if (w_ovf && !s_axis_rx_tlast) w_state_nxt = ST_DROP;
         ST_DROP: if (s_axis_rx_tvalid && s_axis_rx_tlast) w_state_nxt = ST_PASS;
         default: w_state_nxt = ST_PASS;
      endcase
   end

   // ---------------- read side ----------------
   assign w_rptr_nxt = r_rptr + AW'(1);
   assign w_hd_data  = r_mem_data[r_rptr];
   assign w_hd_keep  = r_mem_keep[r_rptr];
   assign w_hd_last  = r_mem_last[r_rptr];
   assign w_hd_user  = r_mem_user[r_rptr];
   assign w_nx_data  = r_mem_data[w_rptr_nxt];
   assign w_nx_keep  = r_mem_keep[w_rptr_nxt];
   assign w_nx_last  = r_mem_last[w_rptr_nxt];
   assign w_nx_user  = r_mem_user[w_rptr_nxt];

   assign w_xfer = r_tvalid & m_axis_tready;
   // Shown half is final when it is the second half or the head has no
   // second half. The head stays counted until that final half transfers.
   assign w_pop  = w_xfer & (r_half | ~w_hd_keep[2]);

   // Next contents of the output register. When the final half pops, the
   // following entry is preloaded so a 1-half-per-cycle stream is sustained.
   always_comb begin
      w_o_valid  = r_tvalid;
      w_o_data   = r_tdata;
      w_o_keep   = r_tkeep;
      w_o_last   = r_tlast;
      w_o_user   = r_tuser;
      w_half_nxt = r_half;
      if (!r_tvalid) begin
         if (r_cnt != '0) begin
            w_o_valid  = 1'b1;
            w_o_data   = w_hd_data[0:15];
            w_o_keep   = w_hd_keep[0:1];
            w_o_last   = w_hd_last & ~w_hd_keep[2];
            w_o_user   = w_hd_user & ~w_hd_keep[2];
            w_half_nxt = 1'b0;
         end
      end else if (w_xfer) begin
         if (!w_pop) begin
            w_o_data   = w_hd_data[16:31];
            w_o_keep   = w_hd_keep[2:3];
            w_o_last   = w_hd_last;
            w_o_user   = w_hd_user;
            w_half_nxt = 1'b1;
         end else if (r_cnt >= C_TWO) begin
            w_o_data   = w_nx_data[0:15];
            w_o_keep   = w_nx_keep[0:1];
            w_o_last   = w_nx_last & ~w_nx_keep[2];
            w_o_user   = w_nx_user & ~w_nx_keep[2];
            w_half_nxt = 1'b0;
         end else begin
            w_o_valid  = 1'b0;
            w_o_last   = 1'b0;
            w_o_user   = 1'b0;
            w_half_nxt = 1'b0;
         end
      end
   end

   // ---------------- pointers, count, flags, outputs ----------------
   always_ff @(posedge user_clk) begin
      if (ur_ch_reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_cnt    <= '0;
         r_xoff   <= 1'b0;
         r_ovf    <= 1'b0;
         r_half   <= 1'b0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tlast  <= 1'b0;
         r_tuser  <= 1'b0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= w_rptr_nxt;
         case ({w_wr, w_pop})
            2'b10:   r_cnt <= r_cnt + C_ONE;
            2'b01:   r_cnt <= r_cnt - C_ONE;
            default: r_cnt <= r_cnt;
         endcase
         // hysteresis: hold between the two thresholds
         if (r_cnt >= C_XOFF)     r_xoff <= 1'b1;
         else if (r_cnt <= C_XON) r_xoff <= 1'b0;
         r_ovf    <= w_ovf;
         r_half   <= w_half_nxt;
         r_tvalid <= w_o_valid;
         r_tdata  <= w_o_data;
         r_tkeep  <= w_o_keep;
         r_tlast  <= w_o_last;
         r_tuser  <= w_o_user;
      end
   end

   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tkeep  = r_tkeep;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tuser  = r_tuser;
   assign nfc_xoff      = r_xoff;
   assign overflow_err  = r_ovf;
   assign fill_count    = r_cnt;

endmodule

// File: tb/tb_aurora_rx_32to16_adapter.sv
// ---------------------------------------------------------------------------
// Directed bench for aurora_rx_32to16_adapter (DEPTH=32, XOFF=20, XON=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_aurora_rx_32to16_adapter;
   localparam int DEPTH = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          user_clk = 1'b0;
   logic          ur_ch_reset;
   logic [0:31]   rx_tdata;
   logic [0:3]    rx_tkeep;
   logic          rx_tvalid;
   logic          rx_tlast;
   logic          rx_tuser;
   logic [0:15]   m_tdata;
   logic [0:1]    m_tkeep;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;
   logic          m_tuser;
   logic          nfc_xoff;
   logic          overflow_err;
   logic [CW-1:0] fill_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 user_clk = ~user_clk;

   aurora_rx_32to16_adapter #(.DEPTH(DEPTH), .XOFF_THRESH(20), .XON_THRESH(8)) dut (
      .user_clk         (user_clk),
      .ur_ch_reset      (ur_ch_reset),
      .s_axis_rx_tdata  (rx_tdata),
      .s_axis_rx_tkeep  (rx_tkeep),
      .s_axis_rx_tvalid (rx_tvalid),
      .s_axis_rx_tlast  (rx_tlast),
      .s_axis_rx_tuser  (rx_tuser),
      .m_axis_tdata     (m_tdata),
      .m_axis_tkeep     (m_tkeep),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tready    (m_tready),
      .m_axis_tlast     (m_tlast),
      .m_axis_tuser     (m_tuser),
      .nfc_xoff         (nfc_xoff),
      .overflow_err     (overflow_err),
      .fill_count       (fill_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one shown half: valid plus {data,keep,last,user}
   task automatic chk_half(input string tag, input logic [15:0] d, input logic [1:0] k,
                           input logic l, input logic u);
      chk({tag, "_valid"}, 64'(m_tvalid), 64'(1));
      chk(tag, 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'({d, k, l, u}));
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   // present one beat for exactly one edge
   task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
      rx_tvalid = 1'b1;
      rx_tdata  = d;
      rx_tkeep  = k;
      rx_tlast  = l;
      rx_tuser  = u;
      tick();
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      rx_tuser  = 1'b0;
   endtask

   initial begin
      logic [15:0] eh;
      ur_ch_reset = 1'b1;
      rx_tvalid = 1'b0; rx_tdata = '0; rx_tkeep = '0; rx_tlast = 1'b0; rx_tuser = 1'b0;
      m_tready = 1'b0;
      tick(); tick();

      // ---- reset state ----
      chk("rst_tvalid", 64'(m_tvalid), 64'(0));
      chk("rst_fill",   64'(fill_count), 64'(0));
      chk("rst_xoff",   64'(nfc_xoff), 64'(0));
      chk("rst_ovf",    64'(overflow_err), 64'(0));
      chk("rst_lastuser", 64'({m_tlast, m_tuser}), 64'(0));
      ur_ch_reset = 1'b0;
      m_tready = 1'b1;

      // ---- 3-beat frame, keep 1111/1111/1100 ----
      beat(32'h11223344, 4'b1111, 1'b0, 1'b0);
      chk("f1_lat_tvalid", 64'(m_tvalid), 64'(0));
      chk("f1_fill1", 64'(fill_count), 64'(1));
      beat(32'h55667788, 4'b1111, 1'b0, 1'b0);
      chk_half("f1_h0", 16'h1122, 2'b11, 1'b0, 1'b0);
      chk("f1_fill2", 64'(fill_count), 64'(2));
      beat(32'h99AABBCC, 4'b1100, 1'b1, 1'b0);
      chk_half("f1_h1", 16'h3344, 2'b11, 1'b0, 1'b0);
      chk("f1_fill3", 64'(fill_count), 64'(3));
      tick();
      chk_half("f1_h2", 16'h5566, 2'b11, 1'b0, 1'b0);
      chk("f1_fill4", 64'(fill_count), 64'(2));
      tick();
      chk_half("f1_h3", 16'h7788, 2'b11, 1'b0, 1'b0);
      tick();
      chk_half("f1_h4", 16'h99AA, 2'b11, 1'b1, 1'b0);
      chk("f1_fill5", 64'(fill_count), 64'(1));
      tick();
      chk("f1_end_tvalid", 64'(m_tvalid), 64'(0));
      chk("f1_end_fill", 64'(fill_count), 64'(0));

      // ---- single beat, keep 1000, tuser ----
      beat(32'hDEAD0000, 4'b1000, 1'b1, 1'b1);
      chk("f2_lat_tvalid", 64'(m_tvalid), 64'(0));
      tick();
      chk_half("f2_h0", 16'hDEAD, 2'b10, 1'b1, 1'b1);
      tick();
      chk("f2_end_tvalid", 64'(m_tvalid), 64'(0));

      // ---- XOFF hysteresis: 25 beats with tready low ----
      m_tready = 1'b0;
      for (int i = 0; i < 25; i++) begin
         beat({8'hC0, 8'(i), 8'hC1, 8'(i)}, 4'b1111, 1'(i == 24), 1'b0);
         chk("x_fill", 64'(fill_count), 64'(i + 1));
         // count reaches 20 after beat 19; XOFF shows one edge later
         chk("x_xoff_rise", 64'(nfc_xoff), 64'(i >= 20));
      end
      m_tready = 1'b1;
      for (int j = 0; j < 50; j++) begin
         eh = (j % 2 == 0) ? {8'hC0, 8'(j / 2)} : {8'hC1, 8'(j / 2)};
         chk_half("x_drain", eh, 2'b11, 1'(j == 49), 1'b0);
         chk("x_drain_fill", 64'(fill_count), 64'(25 - j / 2));
         // XOFF reflects the count before the last edge; clears once that is <= 8
         chk("x_xoff_fall", 64'(nfc_xoff), 64'((j == 0) ? 1 : ((25 - (j - 1) / 2) > 8)));
         tick();
      end
      chk("x_end_tvalid", 64'(m_tvalid), 64'(0));
      chk("x_end_fill", 64'(fill_count), 64'(0));
      chk("x_end_xoff", 64'(nfc_xoff), 64'(0));

      // ---- overflow: 40-beat frame into 32 entries ----
      m_tready = 1'b0;
      for (int k = 0; k < 40; k++) begin
         beat({8'hB0, 8'(k), 8'hB1, 8'(k)}, 4'b1111, 1'(k == 39), 1'b0);
         chk("o_ovf", 64'(overflow_err), 64'(k == 31));
         chk("o_fill", 64'(fill_count), 64'((k + 1 < 32) ? k + 1 : 32));
      end
      // ---- new 2-beat frame while full: dropped, one pulse ----
      beat(32'hA1A2A3A4, 4'b1111, 1'b0, 1'b0);
      chk("full_ovf0", 64'(overflow_err), 64'(1));
      chk("full_fill0", 64'(fill_count), 64'(32));
      beat(32'hA5A6A7A8, 4'b1111, 1'b1, 1'b0);
      chk("full_ovf1", 64'(overflow_err), 64'(0));
      chk("full_fill1", 64'(fill_count), 64'(32));
      m_tready = 1'b1;
      for (int j = 0; j < 64; j++) begin
         eh = (j % 2 == 0) ? {8'hB0, 8'(j / 2)} : {8'hB1, 8'(j / 2)};
         chk_half("o_drain", eh, 2'b11, 1'(j == 63), 1'(j == 63));
         chk("o_drain_fill", 64'(fill_count), 64'(32 - j / 2));
         tick();
      end
      chk("o_end_tvalid", 64'(m_tvalid), 64'(0));
      chk("o_end_fill", 64'(fill_count), 64'(0));
      chk("o_end_xoff", 64'(nfc_xoff), 64'(0));

      // next frame stored intact
      beat(32'hE1E2E3E4, 4'b1111, 1'b0, 1'b0);
      chk("n_lat_tvalid", 64'(m_tvalid), 64'(0));
      beat(32'hF1F2F3F4, 4'b1110, 1'b1, 1'b1);
      chk_half("n_h0", 16'hE1E2, 2'b11, 1'b0, 1'b0);
      tick();
      chk_half("n_h1", 16'hE3E4, 2'b11, 1'b0, 1'b0);
      tick();
      chk_half("n_h2", 16'hF1F2, 2'b11, 1'b0, 1'b0);
      tick();
      chk_half("n_h3", 16'hF3F4, 2'b10, 1'b1, 1'b1);
      tick();
      chk("n_end_tvalid", 64'(m_tvalid), 64'(0));

      // ---- reset mid-readout ----
      m_tready = 1'b0;
      for (int i = 0; i < 22; i++) beat({8'hD0, 8'(i), 8'hD1, 8'(i)}, 4'b1111, 1'b0, 1'b0);
      tick();
      chk("r_pre_xoff", 64'(nfc_xoff), 64'(1));
      chk("r_pre_fill", 64'(fill_count), 64'(22));
      m_tready = 1'b1;
      tick();
      chk_half("r_pre_half", 16'hD100, 2'b11, 1'b0, 1'b0);
      ur_ch_reset = 1'b1;
      tick();
      ur_ch_reset = 1'b0;
      chk("r_tvalid", 64'(m_tvalid), 64'(0));
      chk("r_fill", 64'(fill_count), 64'(0));
      chk("r_xoff", 64'(nfc_xoff), 64'(0));
      chk("r_ovf", 64'(overflow_err), 64'(0));
      beat(32'h0BADF00D, 4'b1110, 1'b1, 1'b0);
      chk("r_lat_tvalid", 64'(m_tvalid), 64'(0));
      tick();
      chk_half("r_h0", 16'h0BAD, 2'b11, 1'b0, 1'b0);
      tick();
      chk_half("r_h1", 16'hF00D, 2'b10, 1'b1, 1'b0);
      tick();
      chk("r_end_tvalid", 64'(m_tvalid), 64'(0));
      chk("r_end_fill", 64'(fill_count), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
